// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage_if: ID-side and EX-side bundle of the ID/EX operand stage.
//   i_id_*          : decoded instruction from ID, with i_id_valid / o_id_ready
//   i_flush         : kill held and incoming instruction
//   i_mem_*, i_wb_* : forwarding sources (MEM result, WB write port)
//   i_ex_ready      : EX accepts; o_ex_valid qualifies the o_* operand bundle
// The stage connects through modport slave; the pipeline driving it uses master.
interface ex_operand_stage_if #(
  parameter int XLEN = 32,
  parameter int REGA = 5
);
  logic            i_id_valid;
  logic            o_id_ready;
  logic [XLEN-1:0] i_id_pc;
  logic [6:0]      i_id_opcode;
  logic [2:0]      i_id_funct3;
  logic            i_id_funct7b5;
  logic [REGA-1:0] i_id_rs1_addr;
  logic [REGA-1:0] i_id_rs2_addr;
  logic [REGA-1:0] i_id_rd_addr;
  logic [XLEN-1:0] i_id_rs1_data;
  logic [XLEN-1:0] i_id_rs2_data;
  logic [XLEN-1:0] i_id_imm;
  logic            i_flush;
  logic            i_mem_wen;
  logic [REGA-1:0] i_mem_rd;
  logic            i_mem_is_load;
  logic [XLEN-1:0] i_mem_data;
  logic            i_wb_wen;
  logic [REGA-1:0] i_wb_rd;
  logic [XLEN-1:0] i_wb_data;
  logic            i_ex_ready;
  logic            o_ex_valid;
  logic [XLEN-1:0] o_alu_in1;
  logic [XLEN-1:0] o_alu_in2;
  logic [2:0]      o_alu_ctrl;
  logic [REGA-1:0] o_ex_rd;
  logic [XLEN-1:0] o_ex_pc;
  logic [XLEN-1:0] o_ex_store_data;
  logic [2:0]      o_ex_funct3;

  modport slave (
    input  i_id_valid, i_id_pc, i_id_opcode, i_id_funct3, i_id_funct7b5,
           i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr, i_id_rs1_data,
           i_id_rs2_data, i_id_imm, i_flush, i_mem_wen, i_mem_rd,
           i_mem_is_load, i_mem_data, i_wb_wen, i_wb_rd, i_wb_data, i_ex_ready,
    output o_id_ready, o_ex_valid, o_alu_in1, o_alu_in2, o_alu_ctrl, o_ex_rd,
           o_ex_pc, o_ex_store_data, o_ex_funct3
  );

  modport master (
    output i_id_valid, i_id_pc, i_id_opcode, i_id_funct3, i_id_funct7b5,
           i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr, i_id_rs1_data,
           i_id_rs2_data, i_id_imm, i_flush, i_mem_wen, i_mem_rd,
           i_mem_is_load, i_mem_data, i_wb_wen, i_wb_rd, i_wb_data, i_ex_ready,
    input  o_id_ready, o_ex_valid, o_alu_in1, o_alu_in2, o_alu_ctrl, o_ex_rd,
           o_ex_pc, o_ex_store_data, o_ex_funct3
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX boundary register feeding the ALU.
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   bus (slave)    : ID handshake and instruction fields in, forwarding
//                    sources in, EX handshake and ALU operand bundle out.
// One instruction is held; decode is done at capture, operand forwarding is
// applied combinationally at the outputs. A load-use dependency on the MEM
// stage holds the instruction (bubble to EX, stall to ID) until it clears.
module ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int REGA = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  ex_operand_stage_if.slave bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b111;

  // Encoding 0 selects the register operand so a cleared stage drives zeros.
  localparam logic [1:0] SEL1_RS1  = 2'd0;
  localparam logic [1:0] SEL1_PC   = 2'd1;
  localparam logic [1:0] SEL1_ZERO = 2'd2;
  localparam logic [1:0] SEL2_RS2  = 2'd0;
  localparam logic [1:0] SEL2_IMM  = 2'd1;
  localparam logic [1:0] SEL2_FOUR = 2'd2;

  logic            valid_q,    valid_d;
  logic [XLEN-1:0] pc_q,       pc_d;
  logic [REGA-1:0] rs1_addr_q, rs1_addr_d;
  logic [REGA-1:0] rs2_addr_q, rs2_addr_d;
  logic [REGA-1:0] rd_q,       rd_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q,      imm_d;
  logic [2:0]      funct3_q,   funct3_d;
  logic [2:0]      ctrl_q,     ctrl_d;
  logic [1:0]      sel1_q,     sel1_d;
  logic [1:0]      sel2_q,     sel2_d;
  logic            use_rs1_q,  use_rs1_d;
  logic            use_rs2_q,  use_rs2_d;

  logic [2:0] dec_ctrl;
  logic [1:0] dec_sel1, dec_sel2;
  logic       dec_use_rs1, dec_use_rs2;

  logic hazard, ex_valid, id_ready, capture;
  logic mem_fwd_ok;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd, op1, op2, alu_in2;

  // Decode of the incoming instruction; unknown opcodes become 0 + imm, add.
  always_comb begin
    dec_ctrl    = ALU_ADD;
    dec_sel1    = SEL1_ZERO;
    dec_sel2    = SEL2_IMM;
    dec_use_rs1 = 1'b0;
    dec_use_rs2 = 1'b0;
    unique case (bus.i_id_opcode)
      OPC_OP, OPC_OP_IMM: begin
        dec_sel1    = SEL1_RS1;
        dec_use_rs1 = 1'b1;
        if (bus.i_id_opcode == OPC_OP) begin
          dec_sel2    = SEL2_RS2;
          dec_use_rs2 = 1'b1;
        end
        unique case (bus.i_id_funct3)
          3'b000: dec_ctrl = (bus.i_id_opcode == OPC_OP && bus.i_id_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: dec_ctrl = ALU_SLL;
          3'b010,
          3'b011: dec_ctrl = ALU_SUB;
          3'b100: dec_ctrl = ALU_XOR;
          3'b101: dec_ctrl = bus.i_id_funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: dec_ctrl = ALU_OR;
          default: dec_ctrl = ALU_AND;
        endcase
      end
      OPC_LOAD: begin
        dec_sel1    = SEL1_RS1;
        dec_use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        dec_sel1    = SEL1_RS1;
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        dec_ctrl    = ALU_SUB;
        dec_sel1    = SEL1_RS1;
        dec_sel2    = SEL2_RS2;
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b1;
      end
      OPC_LUI:   dec_sel1 = SEL1_ZERO;
      OPC_AUIPC: dec_sel1 = SEL1_PC;
      OPC_JAL: begin
        dec_sel1 = SEL1_PC;
        dec_sel2 = SEL2_FOUR;
      end
      OPC_JALR: begin
        dec_sel1    = SEL1_PC;
        dec_sel2    = SEL2_FOUR;
        dec_use_rs1 = 1'b1;
      end
      default: ;
    endcase
  end

  assign hazard = bus.i_mem_wen && bus.i_mem_is_load && (bus.i_mem_rd != '0) &&
                  ((use_rs1_q && bus.i_mem_rd == rs1_addr_q) ||
                   (use_rs2_q && bus.i_mem_rd == rs2_addr_q));
  assign ex_valid = valid_q && !hazard;
  assign id_ready = !valid_q || (ex_valid && bus.i_ex_ready);
  assign capture  = bus.i_id_valid && id_ready && !bus.i_flush;

  function automatic logic wb_hit(input logic [REGA-1:0] addr);
    return bus.i_wb_wen && (bus.i_wb_rd != '0) && (bus.i_wb_rd == addr);
  endfunction

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rd_d       = rd_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    funct3_d   = funct3_q;
    ctrl_d     = ctrl_q;
    sel1_d     = sel1_q;
    sel2_d     = sel2_q;
    use_rs1_d  = use_rs1_q;
    use_rs2_d  = use_rs2_q;

    if (bus.i_flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
    end else if (ex_valid && bus.i_ex_ready) begin
      valid_d = 1'b0;
    end

    if (capture) begin
      pc_d       = bus.i_id_pc;
      rs1_addr_d = bus.i_id_rs1_addr;
      rs2_addr_d = bus.i_id_rs2_addr;
      rd_d       = bus.i_id_rd_addr;
      // Write-through: the register file has not seen this cycle's WB yet.
      rs1_data_d = wb_hit(bus.i_id_rs1_addr) ? bus.i_wb_data : bus.i_id_rs1_data;
      rs2_data_d = wb_hit(bus.i_id_rs2_addr) ? bus.i_wb_data : bus.i_id_rs2_data;
      imm_d      = bus.i_id_imm;
      funct3_d   = bus.i_id_funct3;
      ctrl_d     = dec_ctrl;
      sel1_d     = dec_sel1;
      sel2_d     = dec_sel2;
      use_rs1_d  = dec_use_rs1;
      use_rs2_d  = dec_use_rs2;
    end else begin
      // Keep held operands current so a long stall never loses a WB result.
      if (wb_hit(rs1_addr_q)) rs1_data_d = bus.i_wb_data;
      if (wb_hit(rs2_addr_q)) rs2_data_d = bus.i_wb_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      funct3_q   <= '0;
      ctrl_q     <= '0;
      sel1_q     <= '0;
      sel2_q     <= '0;
      use_rs1_q  <= 1'b0;
      use_rs2_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_q       <= rd_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      funct3_q   <= funct3_d;
      ctrl_q     <= ctrl_d;
      sel1_q     <= sel1_d;
      sel2_q     <= sel2_d;
      use_rs1_q  <= use_rs1_d;
      use_rs2_q  <= use_rs2_d;
    end
  end

  // A loading MEM instruction has no data yet, so it never forwards.
  assign mem_fwd_ok = bus.i_mem_wen && !bus.i_mem_is_load;

  function automatic logic [XLEN-1:0] fwd(input logic [REGA-1:0] addr,
                                          input logic [XLEN-1:0] held);
    if (addr == '0)                                 return '0;
    else if (mem_fwd_ok && bus.i_mem_rd == addr)    return bus.i_mem_data;
    else if (bus.i_wb_wen && bus.i_wb_rd == addr)   return bus.i_wb_data;
    else                                            return held;
  endfunction

  assign rs1_fwd = fwd(rs1_addr_q, rs1_data_q);
  assign rs2_fwd = fwd(rs2_addr_q, rs2_data_q);

  always_comb begin
    unique case (sel1_q)
      SEL1_RS1: op1 = rs1_fwd;
      SEL1_PC:  op1 = pc_q;
      default:  op1 = '0;
    endcase
    unique case (sel2_q)
      SEL2_RS2:  op2 = rs2_fwd;
      SEL2_IMM:  op2 = imm_q;
      default:   op2 = XLEN'(4);
    endcase
  end

  always_comb begin
    alu_in2 = op2;
    if (ctrl_q == ALU_SRA || ctrl_q == ALU_SRL || ctrl_q == ALU_SLL)
      alu_in2 = {{(XLEN-5){1'b0}}, op2[4:0]};
  end

  assign bus.o_id_ready      = id_ready;
  assign bus.o_ex_valid      = ex_valid;
  assign bus.o_alu_in1       = op1;
  assign bus.o_alu_in2       = alu_in2;
  assign bus.o_alu_ctrl      = ctrl_q;
  assign bus.o_ex_rd         = rd_q;
  assign bus.o_ex_pc         = pc_q;
  assign bus.o_ex_store_data = rs2_fwd;
  assign bus.o_ex_funct3     = funct3_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

  localparam logic [6:0] OP   = 7'b0110011;
  localparam logic [6:0] OPI  = 7'b0010011;
  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] ST   = 7'b0100011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] AUI  = 7'b0010111;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] SYS  = 7'b1110011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_operand_stage_if #(.XLEN(32), .REGA(5)) bus ();

  ex_operand_stage #(.XLEN(32), .REGA(5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // ---------------- reference model ----------------
  logic        m_valid;
  logic [31:0] m_pc, m_v1, m_v2, m_imm;
  logic [6:0]  m_op;
  logic [2:0]  m_f3;
  logic        m_f7;
  logic [4:0]  m_rs1, m_rs2, m_rd;

  function automatic logic m_uses1(input logic [6:0] op);
    return op inside {OP, OPI, LD, ST, BR, JALR};
  endfunction

  function automatic logic m_uses2(input logic [6:0] op);
    return op inside {OP, ST, BR};
  endfunction

  function automatic logic m_hazard();
    return bus.i_mem_wen && bus.i_mem_is_load && bus.i_mem_rd != 0 &&
           ((m_uses1(m_op) && bus.i_mem_rd == m_rs1) || (m_uses2(m_op) && bus.i_mem_rd == m_rs2));
  endfunction

  function automatic logic m_exvalid();
    return m_valid && !m_hazard();
  endfunction

  function automatic logic m_ready();
    return !m_valid || (m_exvalid() && bus.i_ex_ready);
  endfunction

  function automatic logic m_wbhit(input logic [4:0] a);
    return bus.i_wb_wen && bus.i_wb_rd != 0 && bus.i_wb_rd == a;
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] held);
    if (a == 0) return 32'h0;
    if (bus.i_mem_wen && !bus.i_mem_is_load && bus.i_mem_rd == a) return bus.i_mem_data;
    if (bus.i_wb_wen && bus.i_wb_rd == a) return bus.i_wb_data;
    return held;
  endfunction

  function automatic logic [2:0] m_ctrl();
    if (m_op == OP || m_op == OPI) begin
      case (m_f3)
        3'd0: return (m_op == OP && m_f7) ? 3'b001 : 3'b000;
        3'd1: return 3'b111;
        3'd2, 3'd3: return 3'b001;
        3'd4: return 3'b100;
        3'd5: return m_f7 ? 3'b101 : 3'b110;
        3'd6: return 3'b011;
        default: return 3'b010;
      endcase
    end
    if (m_op == BR) return 3'b001;
    return 3'b000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_pc <= '0; m_v1 <= '0; m_v2 <= '0; m_imm <= '0;
      m_op <= '0; m_f3 <= '0; m_f7 <= 1'b0; m_rs1 <= '0; m_rs2 <= '0; m_rd <= '0;
    end else begin
      if (bus.i_flush) m_valid <= 1'b0;
      else if (bus.i_id_valid && m_ready()) m_valid <= 1'b1;
      else if (m_exvalid() && bus.i_ex_ready) m_valid <= 1'b0;

      if (!bus.i_flush && bus.i_id_valid && m_ready()) begin
        m_pc  <= bus.i_id_pc;   m_op  <= bus.i_id_opcode; m_f3 <= bus.i_id_funct3;
        m_f7  <= bus.i_id_funct7b5; m_imm <= bus.i_id_imm;
        m_rs1 <= bus.i_id_rs1_addr; m_rs2 <= bus.i_id_rs2_addr; m_rd <= bus.i_id_rd_addr;
        m_v1  <= m_wbhit(bus.i_id_rs1_addr) ? bus.i_wb_data : bus.i_id_rs1_data;
        m_v2  <= m_wbhit(bus.i_id_rs2_addr) ? bus.i_wb_data : bus.i_id_rs2_data;
      end else begin
        if (m_wbhit(m_rs1)) m_v1 <= bus.i_wb_data;
        if (m_wbhit(m_rs2)) m_v2 <= bus.i_wb_data;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    bus.i_id_valid = 0; bus.i_id_pc = 0; bus.i_id_opcode = 0; bus.i_id_funct3 = 0;
    bus.i_id_funct7b5 = 0; bus.i_id_rs1_addr = 0; bus.i_id_rs2_addr = 0;
    bus.i_id_rd_addr = 0; bus.i_id_rs1_data = 0; bus.i_id_rs2_data = 0; bus.i_id_imm = 0;
    bus.i_flush = 0; bus.i_mem_wen = 0; bus.i_mem_rd = 0; bus.i_mem_is_load = 0;
    bus.i_mem_data = 0; bus.i_wb_wen = 0; bus.i_wb_rd = 0; bus.i_wb_data = 0;
    bus.i_ex_ready = 1;
  endtask

  task automatic present(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [31:0] pc);
    bus.i_id_valid = 1; bus.i_id_opcode = op; bus.i_id_funct3 = f3; bus.i_id_funct7b5 = f7;
    bus.i_id_rs1_addr = rs1; bus.i_id_rs2_addr = rs2; bus.i_id_rd_addr = rd;
    bus.i_id_rs1_data = d1; bus.i_id_rs2_data = d2; bus.i_id_imm = imm; bus.i_id_pc = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    #1;
    n_cmp++; if (bus.o_id_ready !== 1'b1) begin n_err++; $display("FAIL rst_id_ready got=%b exp=1", bus.o_id_ready); end
    n_cmp++; if (bus.o_ex_valid !== 1'b0) begin n_err++; $display("FAIL rst_ex_valid got=%b exp=0", bus.o_ex_valid); end
    n_cmp++; if (bus.o_alu_in1 !== 32'h0) begin n_err++; $display("FAIL rst_in1 got=%h exp=0", bus.o_alu_in1); end
    n_cmp++; if (bus.o_alu_in2 !== 32'h0) begin n_err++; $display("FAIL rst_in2 got=%h exp=0", bus.o_alu_in2); end
    n_cmp++; if (bus.o_alu_ctrl !== 3'b0) begin n_err++; $display("FAIL rst_ctrl got=%b exp=0", bus.o_alu_ctrl); end
    n_cmp++; if (bus.o_ex_rd !== 5'd0 || bus.o_ex_pc !== 32'h0 || bus.o_ex_store_data !== 32'h0 || bus.o_ex_funct3 !== 3'd0) begin
      n_err++; $display("FAIL rst_misc got rd=%h pc=%h sd=%h f3=%h exp all 0", bus.o_ex_rd, bus.o_ex_pc, bus.o_ex_store_data, bus.o_ex_funct3);
    end

    // reset while an instruction is held and EX is stalled
    present(OP, 3'd0, 1'b0, 5'd1, 5'd2, 5'd8, 32'd5, 32'd6, 32'd0, 32'h100);
    step();
    idle();
    bus.i_ex_ready = 0;
    #1;
    n_cmp++; if (bus.o_ex_valid !== 1'b1 || bus.o_ex_pc !== 32'h100) begin
      n_err++; $display("FAIL hold_before_rst got valid=%b pc=%h exp valid=1 pc=100", bus.o_ex_valid, bus.o_ex_pc);
    end
    #1 rst_n = 0;
    #1;
    n_cmp++; if (bus.o_ex_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_valid got=%b exp=0", bus.o_ex_valid); end
    #1 rst_n = 1;
    #1;
    n_cmp++; if (bus.o_id_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready got=%b exp=1", bus.o_id_ready); end
    n_cmp++; if (bus.o_ex_pc !== 32'h0 || bus.o_alu_in1 !== 32'h0 || bus.o_alu_in2 !== 32'h0 || bus.o_ex_rd !== 5'd0) begin
      n_err++; $display("FAIL post_rst_outs got pc=%h in1=%h in2=%h rd=%h exp all 0", bus.o_ex_pc, bus.o_alu_in1, bus.o_alu_in2, bus.o_ex_rd);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    idle();
    present(OP, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'd0, 32'h200);
    #1;
    n_cmp++; if (bus.o_id_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready0 got=%b exp=1", bus.o_id_ready); end
    step();
    present(OPI, 3'd0, 1'b0, 5'd1, 5'd0, 5'd4, 32'd10, 32'd0, 32'd5, 32'h204);
    #1;
    n_cmp++; if (bus.o_ex_valid !== 1'b1) begin n_err++; $display("FAIL sub_valid got=%b exp=1", bus.o_ex_valid); end
    n_cmp++; if (bus.o_alu_in1 !== 32'd10 || bus.o_alu_in2 !== 32'd3) begin
      n_err++; $display("FAIL sub_ops got in1=%0d in2=%0d exp in1=10 in2=3", bus.o_alu_in1, bus.o_alu_in2);
    end
    n_cmp++; if (bus.o_alu_ctrl !== 3'b001 || bus.o_ex_rd !== 5'd3) begin
      n_err++; $display("FAIL sub_ctrl_rd got ctrl=%b rd=%0d exp ctrl=001 rd=3", bus.o_alu_ctrl, bus.o_ex_rd);
    end
    n_cmp++; if (bus.o_id_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready1 got=%b exp=1", bus.o_id_ready); end
    step();
    idle();
    #1;
    n_cmp++; if (bus.o_ex_valid !== 1'b1 || bus.o_alu_in1 !== 32'd10 || bus.o_alu_in2 !== 32'd5 ||
                 bus.o_alu_ctrl !== 3'b000 || bus.o_ex_rd !== 5'd4 || bus.o_ex_pc !== 32'h204) begin
      n_err++; $display("FAIL addi got v=%b in1=%0d in2=%0d ctrl=%b rd=%0d pc=%h exp v=1 in1=10 in2=5 ctrl=000 rd=4 pc=204",
                        bus.o_ex_valid, bus.o_alu_in1, bus.o_alu_in2, bus.o_alu_ctrl, bus.o_ex_rd, bus.o_ex_pc);
    end
    step();
    #1;
    n_cmp++; if (bus.o_ex_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got=%b exp=0", bus.o_ex_valid); end
  endtask

  task automatic test_forwarding();
    idle();
    present(OP, 3'd0, 1'b0, 5'd5, 5'd0, 5'd6, 32'h1, 32'h0, 32'h0, 32'h300);
    step();
    idle();
    bus.i_ex_ready = 0;
    bus.i_mem_wen = 1; bus.i_mem_rd = 5; bus.i_mem_data = 32'h11;
    bus.i_wb_wen = 1;  bus.i_wb_rd = 5;  bus.i_wb_data = 32'h22;
    #1;
    n_cmp++; if (bus.o_alu_in1 !== 32'h11) begin n_err++; $display("FAIL fwd_mem_prio got=%h exp=11", bus.o_alu_in1); end
    bus.i_mem_wen = 0;
    #1;
    n_cmp++; if (bus.o_alu_in1 !== 32'h22) begin n_err++; $display("FAIL fwd_wb got=%h exp=22", bus.o_alu_in1); end
    bus.i_mem_wen = 1; bus.i_mem_is_load = 1; bus.i_wb_wen = 0;
    #1;
    n_cmp++; if (bus.o_alu_in1 !== 32'h1 || bus.o_ex_valid !== 1'b0) begin
      n_err++; $display("FAIL fwd_load_nofwd got in1=%h v=%b exp in1=1 v=0", bus.o_alu_in1, bus.o_ex_valid);
    end
    idle();
    present(OP, 3'd0, 1'b0, 5'd0, 5'd2, 5'd9, 32'h55, 32'h4, 32'h0, 32'h304);
    step();
    idle();
    bus.i_ex_ready = 0;
    bus.i_mem_wen = 1; bus.i_mem_rd = 0; bus.i_mem_data = 32'h77;
    #1;
    n_cmp++; if (bus.o_alu_in1 !== 32'h0 || bus.o_ex_rd !== 5'd9) begin
      n_err++; $display("FAIL fwd_x0 got in1=%h rd=%0d exp in1=0 rd=9", bus.o_alu_in1, bus.o_ex_rd);
    end
    idle();
    step();
  endtask

  task automatic test_load_use();
    idle();
    present(OP, 3'd0, 1'b0, 5'd7, 5'd1, 5'd8, 32'h5, 32'h3, 32'h0, 32'h400);
    step();
    idle();
    present(OPI, 3'd0, 1'b0, 5'd1, 5'd0, 5'd10, 32'h3, 32'h0, 32'h1, 32'h404);
    bus.i_mem_wen = 1; bus.i_mem_is_load = 1; bus.i_mem_rd = 7;
    #1;
    n_cmp++; if (bus.o_ex_valid !== 1'b0 || bus.o_id_ready !== 1'b0) begin
      n_err++; $display("FAIL lu_stall got v=%b rdy=%b exp v=0 rdy=0", bus.o_ex_valid, bus.o_id_ready);
    end
    step();
    bus.i_mem_wen = 0; bus.i_mem_is_load = 0; bus.i_mem_rd = 0;
    bus.i_wb_wen = 1; bus.i_wb_rd = 7; bus.i_wb_data = 32'h99;
    #1;
    n_cmp++; if (bus.o_ex_valid !== 1'b1 || bus.o_alu_in1 !== 32'h99 || bus.o_alu_in2 !== 32'h3 || bus.o_ex_rd !== 5'd8) begin
      n_err++; $display("FAIL lu_release got v=%b in1=%h in2=%h rd=%0d exp v=1 in1=99 in2=3 rd=8",
                        bus.o_ex_valid, bus.o_alu_in1, bus.o_alu_in2, bus.o_ex_rd);
    end
    step();
    idle();
    #1;
    n_cmp++; if (bus.o_ex_rd !== 5'd10 || bus.o_ex_valid !== 1'b1) begin
      n_err++; $display("FAIL lu_next got rd=%0d v=%b exp rd=10 v=1", bus.o_ex_rd, bus.o_ex_valid);
    end
    step();
  endtask

  task automatic test_stall_refresh();
    idle();
    present(OP, 3'd0, 1'b0, 5'd1, 5'd2, 5'd11, 32'h7, 32'h1, 32'h0, 32'h500);
    step();
    idle();
    bus.i_ex_ready = 0;
    bus.i_wb_wen = 1; bus.i_wb_rd = 2; bus.i_wb_data = 32'hABCD;
    #1;
    n_cmp++; if (bus.o_alu_in2 !== 32'hABCD) begin n_err++; $display("FAIL refresh_c1 got=%h exp=abcd", bus.o_alu_in2); end
    for (int c = 2; c <= 3; c++) begin
      step();
      bus.i_wb_wen = 0; bus.i_wb_rd = 0; bus.i_wb_data = 0;
      #1;
      n_cmp++; if (bus.o_alu_in2 !== 32'hABCD || bus.o_ex_store_data !== 32'hABCD || bus.o_ex_valid !== 1'b1) begin
        n_err++; $display("FAIL refresh_c%0d got in2=%h sd=%h v=%b exp in2=abcd sd=abcd v=1",
                          c, bus.o_alu_in2, bus.o_ex_store_data, bus.o_ex_valid);
      end
    end
    bus.i_ex_ready = 1;
    step();
  endtask

  task automatic test_flush_shift();
    idle();
    present(OP, 3'd0, 1'b0, 5'd1, 5'd2, 5'd12, 32'h1, 32'h2, 32'h0, 32'h600);
    step();
    idle();
    present(OPI, 3'd0, 1'b0, 5'd1, 5'd0, 5'd13, 32'h1, 32'h0, 32'h9, 32'h604);
    bus.i_flush = 1;
    step();
    idle();
    #1;
    n_cmp++; if (bus.o_ex_valid !== 1'b0 || bus.o_ex_rd !== 5'd12 || bus.o_id_ready !== 1'b1) begin
      n_err++; $display("FAIL flush got v=%b rd=%0d rdy=%b exp v=0 rd=12 rdy=1", bus.o_ex_valid, bus.o_ex_rd, bus.o_id_ready);
    end
    present(OP, 3'd5, 1'b1, 5'd1, 5'd2, 5'd14, 32'h80000000, 32'h00000125, 32'h0, 32'h608);
    step();
    idle();
    bus.i_ex_ready = 0;
    #1;
    n_cmp++; if (bus.o_ex_valid !== 1'b1 || bus.o_alu_ctrl !== 3'b101 || bus.o_alu_in2 !== 32'd5) begin
      n_err++; $display("FAIL sra got v=%b ctrl=%b in2=%h exp v=1 ctrl=101 in2=5", bus.o_ex_valid, bus.o_alu_ctrl, bus.o_alu_in2);
    end
    n_cmp++; if (bus.o_alu_in1 !== 32'h80000000 || bus.o_ex_store_data !== 32'h125 || bus.o_ex_funct3 !== 3'd5) begin
      n_err++; $display("FAIL sra_misc got in1=%h sd=%h f3=%0d exp in1=80000000 sd=125 f3=5",
                        bus.o_alu_in1, bus.o_ex_store_data, bus.o_ex_funct3);
    end
    bus.i_ex_ready = 1;
    step();
  endtask

  task automatic test_random();
    logic [6:0] ops [10] = '{OP, OPI, LD, ST, BR, LUI, AUI, JAL, JALR, SYS};
    for (int c = 0; c < 600; c++) begin
      logic [31:0] r1, r2, e1, e2;
      logic [2:0]  ectrl;
      bus.i_id_valid    = ($urandom_range(0, 9) < 7);
      bus.i_id_pc       = $urandom;
      bus.i_id_opcode   = ops[$urandom_range(0, 9)];
      bus.i_id_funct3   = 3'($urandom_range(0, 7));
      bus.i_id_funct7b5 = 1'($urandom_range(0, 1));
      bus.i_id_rs1_addr = 5'($urandom_range(0, 7));
      bus.i_id_rs2_addr = 5'($urandom_range(0, 7));
      bus.i_id_rd_addr  = 5'($urandom_range(0, 31));
      bus.i_id_rs1_data = $urandom;
      bus.i_id_rs2_data = $urandom;
      bus.i_id_imm      = $urandom;
      bus.i_flush       = ($urandom_range(0, 15) == 0);
      bus.i_mem_wen     = 1'($urandom_range(0, 1));
      bus.i_mem_rd      = 5'($urandom_range(0, 7));
      bus.i_mem_is_load = ($urandom_range(0, 9) < 3);
      bus.i_mem_data    = $urandom;
      bus.i_wb_wen      = 1'($urandom_range(0, 1));
      bus.i_wb_rd       = 5'($urandom_range(0, 7));
      bus.i_wb_data     = $urandom;
      bus.i_ex_ready    = ($urandom_range(0, 9) < 7);
      #1;
      r1 = m_fwd(m_rs1, m_v1);
      r2 = m_fwd(m_rs2, m_v2);
      ectrl = m_ctrl();
      case (m_op)
        OP, BR:        begin e1 = r1;   e2 = r2;    end
        OPI, LD, ST:   begin e1 = r1;   e2 = m_imm; end
        AUI:           begin e1 = m_pc; e2 = m_imm; end
        JAL, JALR:     begin e1 = m_pc; e2 = 32'd4; end
        default:       begin e1 = 32'd0; e2 = m_imm; end
      endcase
      if (ectrl inside {3'b101, 3'b110, 3'b111}) e2 = e2 % 32;
      n_cmp++; if (bus.o_ex_valid !== m_exvalid()) begin n_err++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bus.o_ex_valid, m_exvalid()); end
      n_cmp++; if (bus.o_id_ready !== m_ready()) begin n_err++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, bus.o_id_ready, m_ready()); end
      n_cmp++; if (bus.o_alu_in1 !== e1) begin n_err++; $display("FAIL rnd_in1 c=%0d got=%h exp=%h", c, bus.o_alu_in1, e1); end
      n_cmp++; if (bus.o_alu_in2 !== e2) begin n_err++; $display("FAIL rnd_in2 c=%0d got=%h exp=%h", c, bus.o_alu_in2, e2); end
      n_cmp++; if (bus.o_alu_ctrl !== ectrl) begin n_err++; $display("FAIL rnd_ctrl c=%0d got=%b exp=%b", c, bus.o_alu_ctrl, ectrl); end
      n_cmp++; if (bus.o_ex_store_data !== r2) begin n_err++; $display("FAIL rnd_store c=%0d got=%h exp=%h", c, bus.o_ex_store_data, r2); end
      n_cmp++; if (bus.o_ex_rd !== m_rd || bus.o_ex_pc !== m_pc || bus.o_ex_funct3 !== m_f3) begin
        n_err++; $display("FAIL rnd_fields c=%0d got rd=%0d pc=%h f3=%0d exp rd=%0d pc=%h f3=%0d",
                          c, bus.o_ex_rd, bus.o_ex_pc, bus.o_ex_funct3, m_rd, m_pc, m_f3);
      end
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_back_to_back();
    test_forwarding();
    test_load_use();
    test_stall_refresh();
    test_flush_shift();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX boundary stage that feeds the ALU: registers one decoded instruction, resolves operand forwarding and produces the ALU operands and 3-bit control, then hands off to EX over a valid/ready pair.
- Detects load-use hazards and holds the instruction until they clear.
- Refreshes held register operands from writeback while it is stalled.

Parameters:
- XLEN, 32, datapath width.
- REGA, 5, register-address width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_id_valid  in  1  ID presents an instruction.
- o_id_ready  out  1  stage can accept this cycle.
- i_id_pc  in  XLEN  instruction PC.
- i_id_opcode  in  7  RV32I opcode.
- i_id_funct3  in  3  funct3.
- i_id_funct7b5  in  1  instr[30].
- i_id_rs1_addr  in  REGA  source register 1 address.
- i_id_rs2_addr  in  REGA  source register 2 address.
- i_id_rd_addr  in  REGA  destination register address.
- i_id_rs1_data  in  XLEN  register-file read data for rs1.
- i_id_rs2_data  in  XLEN  register-file read data for rs2.
- i_id_imm  in  XLEN  sign-extended immediate.
- i_flush  in  1  kill held and incoming instruction.
- i_mem_wen  in  1  MEM stage will write rd.
- i_mem_rd  in  REGA  MEM stage destination.
- i_mem_is_load  in  1  MEM stage instruction is a load; its data is not yet valid.
- i_mem_data  in  XLEN  MEM stage ALU result.
- i_wb_wen  in  1  WB stage writes the register file this cycle.
- i_wb_rd  in  REGA  WB stage destination.
- i_wb_data  in  XLEN  WB stage write data.
- i_ex_ready  in  1  EX accepts this cycle.
- o_ex_valid  out  1  operands are valid for EX.
- o_alu_in1  out  XLEN  ALU operand 1.
- o_alu_in2  out  XLEN  ALU operand 2.
- o_alu_ctrl  out  3  ALU control.
- o_ex_rd  out  REGA  destination register passed to EX.
- o_ex_pc  out  XLEN  PC passed to EX.
- o_ex_store_data  out  XLEN  forwarded rs2 value, used as store data.
- o_ex_funct3  out  3  funct3 passed to EX, for branch/slt result selection.

Behaviour:
- Reset, asynchronous on i_rst_n low: held-valid=0, all held registers=0. Every output is 0 except o_id_ready=1.
- Capture: ID transfer occurs when i_id_valid && o_id_ready. One-cycle latency; o_ex_valid can assert on the next cycle.
- o_id_ready = !held_valid || (o_ex_valid && i_ex_ready).
- o_ex_valid = held_valid && !hazard.
- hazard = i_mem_wen && i_mem_is_load && i_mem_rd!=0 && ((use_rs1 && i_mem_rd==rs1) || (use_rs2 && i_mem_rd==rs2)).
  - While hazard is asserted the instruction holds, EX sees a bubble, and ID is stalled.
- i_flush has priority over everything: the next edge clears held_valid and drops any capture in the same cycle.
- Forwarding (combinational, applied at the outputs), per source register:
  - register address 0 always reads 0;
  - else MEM match (i_mem_wen && !i_mem_is_load) takes the MEM data;
  - else WB match (i_wb_wen) takes the WB data;
  - else the held value.
- WB refresh while holding: each edge without a capture, if i_wb_wen and i_wb_rd is nonzero and matches held rs1/rs2, the held data is overwritten with i_wb_data. On capture, a same-cycle WB match to the incoming rs replaces the register-file data, which gives write-through.
- Decode happens at capture; held: ctrl, in1 select (rs1/pc/zero), in2 select (rs2/imm/const 4), use_rs1, use_rs2.
  - OP (0110011) / OP-IMM (0010011), by funct3:
    - 000: add=000. OP with funct7b5=1 selects sub=001.
    - 001: sll=111.
    - 010 and 011: sub=001 (slt/sltu resolved in EX from the compare flags).
    - 100: xor=100.
    - 101: srl=110, or sra=101 when funct7b5=1; this applies to OP-IMM too.
    - 110: or=011.
    - 111: and=010.
    - OP uses rs2; OP-IMM uses imm.
  - LOAD / STORE: rs1 + imm, add.
  - BRANCH: rs1 - rs2, sub.
  - LUI: 0 + imm, add.
  - AUIPC: pc + imm, add.
  - JAL / JALR: pc + 4, add.
  - Any other opcode: add, no rs use.
  - use_rs1 = 0 for LUI, AUIPC, JAL. use_rs2 = 1 for OP, STORE, BRANCH only.
- Shifts (ctrl 101/110/111): o_alu_in2 = {27'b0, operand[4:0]}.
- o_ex_store_data is the forwarded rs2 regardless of in2 select.
- Every output other than o_ex_valid and o_id_ready shows the held/forwarded values even when invalid. EX ignores them in that case.

Test Plan:
- Reset mid-hold: instruction held and i_ex_ready=0, pull i_rst_n low asynchronously -> o_ex_valid=0 immediately; after release, o_id_ready=1 and all outputs 0.
- Capture `sub x3,x1,x2` (x1=10, x2=3) with i_ex_ready=1 -> next cycle o_ex_valid=1, in1=10, in2=3, ctrl=001, o_ex_rd=3; back-to-back `addi` captured the same cycle.
- Forwarding priority: held rs1=x5; MEM writes x5=0x11 and WB writes x5=0x22 -> in1=0x11. With the MEM write removed -> 0x22. For rs1=x0 with MEM rd=0 -> in1=0.
- Load-use: MEM is a load to x7 (is_load=1), held `add x8,x7,x1` -> o_ex_valid=0 and o_id_ready=0 for 1 cycle. Next cycle (the load in WB, x7=0x99) -> o_ex_valid=1, in1=0x99.
- Stall refresh: i_ex_ready=0 for 3 cycles, and WB writes rs2=0xABCD in cycle 1 only -> in cycles 2-3, in2=0xABCD from the held register.
- Flush and shift: i_flush with i_id_valid=1 -> next cycle o_ex_valid=0. Then `sra` with rs2=0x00000125 -> ctrl=101, in2=5.
